// File: rtl/distance_filter.sv
// Ultrasonic echo-width to centimetre converter: restoring divider, power-of-two
// moving average over in-range samples, and a hysteretic near-obstacle flag.
module distance_filter #(
  parameter int unsigned CYCLES_PER_CM = 2900,
  parameter int unsigned MAX_CM        = 400,
  parameter int unsigned AVG_LOG2      = 2,
  parameter int unsigned NEAR_CM       = 30,
  parameter int unsigned HYST_CM       = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_valid,
  input  logic [21:0] raw_count,
  output logic        busy,
  output logic        dist_valid,
  output logic [9:0]  dist_cm,
  output logic [9:0]  avg_cm,
  output logic        near,
  output logic        out_of_range
);

  localparam int unsigned N  = 1 << AVG_LOG2;
  localparam int unsigned SW = 10 + AVG_LOG2;

  localparam logic [22:0] DIVISOR = 23'(CYCLES_PER_CM);
  localparam logic [21:0] MAX_Q   = 22'(MAX_CM);
  localparam logic [9:0]  MAX_D   = 10'(MAX_CM);
  localparam logic [10:0] SET_V   = 11'(NEAR_CM);
  localparam logic [10:0] CLR_V   = 11'(NEAR_CM + HYST_CM);

  typedef enum logic [1:0] {IDLE, DIV, ACC, OUT} state_t;

  state_t              state_q, state_d;
  logic [21:0]         dividend_q;
  logic [21:0]         quot_q;
  logic [21:0]         rem_q;
  logic [4:0]          cnt_q;
  logic                zero_q;
  logic                primed_q;
  logic [AVG_LOG2-1:0] ptr_q;
  logic [SW-1:0]       sum_q;
  logic [9:0]          win_q [N];
  logic                near_q;
  logic [9:0]          dist_q;
  logic                oor_q;

  logic [22:0]         rem_sh;
  logic                rem_ge;
  logic [21:0]         rem_sub;
  logic                in_range;
  logic [9:0]          value;
  logic [SW-1:0]       sum_upd;
  logic [9:0]          avg_upd;
  logic                near_upd;

  always_comb begin
    state_d    = state_q;
    busy       = (state_q != IDLE);
    dist_valid = (state_q == OUT);
    unique case (state_q)
      IDLE: if (sample_valid) state_d = DIV;
      DIV:  if (cnt_q == 5'd1) state_d = ACC;
      ACC:  state_d = OUT;
      OUT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rem_sh   = {rem_q, dividend_q[21]};
    rem_ge   = (rem_sh >= DIVISOR);
    rem_sub  = 22'(rem_sh - DIVISOR);
    in_range = !zero_q && (quot_q <= MAX_Q);
    value    = quot_q[9:0];
    // The first in-range sample fills the whole window so the average starts at it.
    if (primed_q) sum_upd = sum_q - SW'(win_q[ptr_q]) + SW'(value);
    else          sum_upd = {value, {AVG_LOG2{1'b0}}};
    avg_upd  = sum_upd[SW-1:AVG_LOG2];
    near_upd = near_q;
    if ({1'b0, avg_upd} < SET_V)       near_upd = 1'b1;
    else if ({1'b0, avg_upd} >= CLR_V) near_upd = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend_q <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      zero_q     <= 1'b0;
      primed_q   <= 1'b0;
      ptr_q      <= '0;
      sum_q      <= '0;
      near_q     <= 1'b0;
      dist_q     <= '0;
      oor_q      <= 1'b0;
      for (int unsigned i = 0; i < N; i++) win_q[AVG_LOG2'(i)] <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (sample_valid) begin
          dividend_q <= raw_count;
          quot_q     <= '0;
          rem_q      <= '0;
          cnt_q      <= 5'd22;
          zero_q     <= (raw_count == '0);
        end
        DIV: begin
          dividend_q <= {dividend_q[20:0], 1'b0};
          rem_q      <= rem_ge ? rem_sub : rem_sh[21:0];
          quot_q     <= {quot_q[20:0], rem_ge};
          cnt_q      <= cnt_q - 5'd1;
        end
        ACC: begin
          if (in_range) begin
            dist_q <= value;
            oor_q  <= 1'b0;
            sum_q  <= sum_upd;
            near_q <= near_upd;
            if (primed_q) begin
              win_q[ptr_q] <= value;
              ptr_q        <= ptr_q + AVG_LOG2'(1);
            end else begin
              for (int unsigned i = 0; i < N; i++) win_q[AVG_LOG2'(i)] <= value;
              primed_q <= 1'b1;
            end
          end else begin
            dist_q <= MAX_D;
            oor_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dist_cm      = dist_q;
  assign avg_cm       = sum_q[SW-1:AVG_LOG2];
  assign near         = near_q;
  assign out_of_range = oor_q;

endmodule

// File: tb/tb_distance_filter.sv
// Self-checking bench for distance_filter: a per-cycle compare against a queue-based
// reference model, plus directed sequences with hand-computed expectations.
module tb_distance_filter;

  localparam int unsigned CPC     = 2900;
  localparam int unsigned MAXCM   = 400;
  localparam int unsigned LG      = 2;
  localparam int unsigned NEARCM  = 30;
  localparam int unsigned HYSTCM  = 5;
  localparam int unsigned LATENCY = 24;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_valid = 1'b0;
  logic [21:0] raw_count = '0;
  logic        busy, dist_valid, near, out_of_range;
  logic [9:0]  dist_cm, avg_cm;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  distance_filter #(
    .CYCLES_PER_CM(CPC), .MAX_CM(MAXCM), .AVG_LOG2(LG),
    .NEAR_CM(NEARCM), .HYST_CM(HYSTCM)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .raw_count(raw_count),
    .busy(busy), .dist_valid(dist_valid), .dist_cm(dist_cm), .avg_cm(avg_cm),
    .near(near), .out_of_range(out_of_range)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the window is a queue with the oldest entry at the front.
  int unsigned m_win[$];
  int unsigned m_dist, m_avg, m_raw, m_due;
  bit          m_near, m_oor, m_pending;

  task automatic model_reset();
    m_win.delete();
    m_dist = 0; m_avg = 0; m_near = 0; m_oor = 0; m_pending = 0; m_due = 0;
  endtask

  task automatic model_apply(input int unsigned raw);
    int unsigned q, s;
    q = raw / CPC;
    if (raw == 0 || q > MAXCM) begin
      m_dist = MAXCM;
      m_oor  = 1;
    end else begin
      m_dist = q;
      m_oor  = 0;
      if (m_win.size() == 0) begin
        for (int i = 0; i < (1 << LG); i++) m_win.push_back(q);
      end else begin
        void'(m_win.pop_front());
        m_win.push_back(q);
      end
      s = 0;
      foreach (m_win[i]) s += m_win[i];
      m_avg = s / (1 << LG);
      if (m_avg < NEARCM) m_near = 1;
      else if (m_avg >= NEARCM + HYSTCM) m_near = 0;
    end
  endtask

  initial model_reset();

  always @(negedge clk) begin
    bit busy_exp, dv_exp;
    if (!rst_n) begin
      model_reset();
      check("rst_outputs", {busy, dist_valid, near, out_of_range, dist_cm, avg_cm}, '0);
    end else begin
      busy_exp = m_pending;
      dv_exp   = m_pending && (cyc == m_due);
      if (dv_exp) model_apply(m_raw);
      check("busy", busy, busy_exp);
      check("dist_valid", dist_valid, dv_exp);
      check("dist_cm", dist_cm, m_dist);
      check("avg_cm", avg_cm, m_avg);
      check("near", near, m_near);
      check("out_of_range", out_of_range, m_oor);
      if (dv_exp) m_pending = 0;
      if (sample_valid && !busy_exp) begin
        m_pending = 1;
        m_due     = cyc + LATENCY;
        m_raw     = raw_count;
      end
    end
  end

  // One accepted sample, then literal expectations at its dist_valid.
  task automatic send(input int unsigned raw, input int unsigned e_dist, input int unsigned e_avg,
                      input bit e_near, input bit e_oor);
    int unsigned t0;
    bit got;
    @(posedge clk); #2;
    sample_valid = 1'b1;
    raw_count    = 22'(raw);
    t0           = cyc;
    @(posedge clk); #2;
    sample_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (dist_valid) got = 1;
    end
    check("dv_seen", got, 1'b1);
    if (got) begin
      check("latency", cyc - t0, LATENCY);
      check("lit_dist", dist_cm, e_dist);
      check("lit_avg", avg_cm, e_avg);
      check("lit_near", near, e_near);
      check("lit_oor", out_of_range, e_oor);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0, dv_cnt, gap, r;
    int unsigned avg_a[4] = '{80, 60, 40, 20};
    bit          near_a[4] = '{0, 0, 0, 1};
    int unsigned avg_b[4] = '{23, 26, 29, 32};
    int unsigned avg_c[4] = '{34, 36, 38, 40};
    bit          near_c[4] = '{1, 0, 0, 0};

    #1;
    check("rst_async", {busy, dist_valid, near, out_of_range, dist_cm, avg_cm}, '0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    check("idle_busy", busy, 1'b0);

    send(290000, 100, 100, 0, 0);
    for (int i = 0; i < 4; i++) send(58000, 20, avg_a[i], near_a[i], 0);
    for (int i = 0; i < 4; i++) send(92800, 32, avg_b[i], 1, 0);
    for (int i = 0; i < 4; i++) send(116000, 40, avg_c[i], near_c[i], 0);
    send(0, 400, 40, 0, 1);
    send(1163000, 400, 40, 0, 1);
    send(2899, 0, 30, 0, 0);
    send(1160000, 400, 120, 0, 0);

    // Pulses inside the busy window, including the OUT cycle, must be dropped.
    @(posedge clk); #2;
    sample_valid = 1'b1;
    raw_count    = 22'd58000;
    t0           = cyc;
    dv_cnt       = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      sample_valid = (cyc == t0 + 5) || (cyc == t0 + 24);
      raw_count    = 22'd2900;
      @(negedge clk);
      if (dist_valid) dv_cnt++;
    end
    sample_valid = 1'b0;
    check("drop_dv_count", dv_cnt, 1);
    check("drop_dist", dist_cm, 20);

    for (int n = 0; n < 300; n++) begin
      gap = $urandom_range(0, 40);
      repeat (gap) @(posedge clk);
      case ($urandom_range(0, 7))
        0:       r = 0;
        1:       r = $urandom_range(1_100_000, 4_194_303);
        default: r = $urandom_range(1, 1_200_000);
      endcase
      @(posedge clk); #2;
      sample_valid = 1'b1;
      raw_count    = 22'(r);
      @(posedge clk); #2;
      sample_valid = 1'b0;
    end
    repeat (30) @(posedge clk);

    // Reset in the middle of a division: no result, and the next sample re-primes.
    @(posedge clk); #2;
    sample_valid = 1'b1;
    raw_count    = 22'd290000;
    t0           = cyc;
    @(posedge clk); #2;
    sample_valid = 1'b0;
    while (cyc < t0 + 10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_mid_async", {busy, dist_valid, near, out_of_range, dist_cm, avg_cm}, '0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    dv_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dist_valid) dv_cnt++;
    end
    check("rst_no_dv", dv_cnt, 0);
    send(116000, 40, 40, 0, 0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/distance_filter.md
# distance_filter

Downstream stage of the ultrasonic proximity sensor. It accepts the raw echo-width count (50 MHz clock cycles) whenever a measurement completes and converts it to whole centimetres with a sequential restoring divider. In-range results pass through a power-of-two moving-average window, and a hysteretic `near` obstacle flag is derived from the average. Its outputs drive the LED and display logic in place of the raw count.

## Interface
- `CYCLES_PER_CM`, default 2900: echo cycles per cm of range (58 µs/cm at 50 MHz).
- `MAX_CM`, default 400: largest valid distance. Larger quotients are out of range.
- `AVG_LOG2`, default 2: log2 of the averaging window depth (N = 4).
- `NEAR_CM`, default 30: `near` sets when `avg_cm < NEAR_CM`.
- `HYST_CM`, default 5: `near` clears when `avg_cm >= NEAR_CM + HYST_CM`.
- `clk` in 1: system clock, 50 MHz. One clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `sample_valid` in 1: one-cycle pulse; `raw_count` is valid in the same cycle.
- `raw_count` in 22: echo width in clock cycles.
- `busy` in/out: out 1, high whenever state ≠ IDLE.
- `dist_valid` out 1: one-cycle pulse; `dist_cm`, `avg_cm`, `near` and `out_of_range` are updated in the same cycle.
- `dist_cm` out 10: instantaneous distance of the last sample. Holds between pulses.
- `avg_cm` out 10: moving average of in-range samples.
- `near` out 1: obstacle flag with hysteresis.
- `out_of_range` out 1: last sample was rejected. Holds until the next `dist_valid`.

## Operation
- States: IDLE, DIV, ACC, OUT.
- **IDLE**
  - `sample_valid` = 1 → capture `raw_count` into the dividend register, clear the quotient and remainder, load the iteration counter with 22, go to DIV.
- **DIV**
  - One restoring-division step per cycle, MSB first.
  - Remainder = (rem << 1) | next dividend bit. If rem ≥ `CYCLES_PER_CM`, subtract it and shift 1 into the quotient.
  - After 22 steps go to ACC. The 22-bit quotient is `floor(raw/CYCLES_PER_CM)`.
- **ACC**
  - Out of range when quotient > `MAX_CM` or `raw_count` == 0:
    - `dist_cm` = `MAX_CM`, `out_of_range` = 1.
    - Window, sum, `avg_cm` and `near` are unchanged.
  - Otherwise `dist_cm` = quotient[9:0] and `out_of_range` = 0.
    - First in-range sample since reset (`primed` = 0): write the value to all N window entries, set sum = value·N, set `primed`.
    - Later samples: sum ← sum − oldest + new, overwrite the oldest entry, advance the circular pointer (wraps N−1 → 0).
    - Sum width is 10 + `AVG_LOG2` bits; it cannot overflow.
  - Go to OUT.
- **OUT**
  - `avg_cm` = sum >> `AVG_LOG2` (truncating).
  - `near` update: set if `avg_cm < NEAR_CM`, clear if `avg_cm >= NEAR_CM+HYST_CM`, otherwise hold.
  - `dist_valid` = 1. Go to IDLE.
- **Drop rule:** `sample_valid` while `busy` = 1, including in OUT, is ignored. No queuing and no side effects.
- **Reset:** `busy`, `dist_valid`, `near`, `out_of_range`, `primed` and the pointer are 0. `dist_cm`, `avg_cm`, sum and window entries are 0. State is IDLE.
- **Reset mid-operation:** any in-flight division is abandoned with no `dist_valid`. The next sample after reset re-primes the window.

## Timing
- Capture edge E (IDLE with `sample_valid` = 1). `busy` rises after E.
- DIV occupies cycles E+1 … E+22. ACC is E+23.
- OUT is E+24: `dist_valid` and all updated outputs are visible in that cycle. Latency is 24 cycles.
- `busy` falls after E+24. The earliest next accepted sample is at E+25.
- The peak accept rate is 1 per 25 cycles, far faster than the 250 ms measurement rate.
- `avg_cm`/`near` changes and `dist_valid` appear in the same cycle.

## Test plan
- **Reset values:** assert `rst_n` = 0 asynchronously mid-cycle → all outputs 0 immediately. Release and hold `sample_valid` = 0 → `busy` stays 0.
- **Conversion and latency:** `raw_count` = 290000 after reset → `dist_valid` exactly 24 cycles after capture. `dist_cm` = 100, `avg_cm` = 100 (primed), `near` = 0. Also `raw_count` = 2899 → `dist_cm` = 0, `out_of_range` = 0.
- **Averaging:** after the 100 cm prime, send 58000 (20 cm) ×4 → `avg_cm` = 80, 60, 40, 20.
  - `near` goes 0, 0, 0, 1 (sets on the fourth sample).
- **Hysteresis:** then send 92800 (32 cm) ×4 → `avg_cm` = 23, 26, 29, 32 and `near` stays 1.
  - Then 40 cm ×4 → `avg_cm` = 34, 36, … and `near` clears on the first average ≥ 35.
- **Out of range:** `raw_count` = 0, and separately `raw_count` = 1163000 (401 cm) → `out_of_range` = 1, `dist_cm` = 400.
  - `avg_cm` and `near` are unchanged. The next in-range sample clears `out_of_range`.
- **Busy drop and reset mid-op:**
  - Pulse `sample_valid` at E+5 and again at E+24 → ignored; exactly one `dist_valid`.
  - Drop `rst_n` at E+10 → no `dist_valid` follows. The next sample re-primes, so `avg_cm` equals that sample's `dist_cm`.
